// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand width, iteration
// counter width, the all-ones result used for divide-by-zero, and the
// controller state encoding.
package div_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;   // must be able to hold WIDTH

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit (master) and the divider
// (slave).
//   start     master -> slave  request pulse, sampled only while idle
//   sgn       master -> slave  1 = signed division (signed builds only)
//   dividend  master -> slave  numerator, sampled with start
//   divisor   master -> slave  denominator, sampled with start
//   busy      slave -> master  accepted and not yet finished
//   done      slave -> master  one-cycle result-valid pulse
//   quotient  slave -> master  result, held until the next result
//   remainder slave -> master  result, held until the next result
//   div_zero  slave -> master  last accepted divisor was zero
interface seq_divider_if;
   import div_pkg::*;

   logic             start;
   logic             sgn;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, sgn, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, sgn, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   rem      partial remainder before this step
//   q_msb    next dividend bit shifted in (MSB of the quotient shifter)
//   divisor  divisor magnitude
//   next_rem partial remainder after this step
//   q_bit    quotient bit produced by this step
module div_step
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] rem,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   // The shifted remainder keeps rem's top bit: with a divisor above
   // 2^(WIDTH-1) the partial remainder can itself exceed that, and dropping
   // the bit would give a wrong compare.
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   always_comb begin
      shifted  = {rem, q_msb};
      trial    = {1'b0, shifted} - {2'b00, divisor};
      q_bit    = ~trial[WIDTH+1];
      next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_if.slave request/result bundle
// Build option: define DIV_SIGNED_EN to honour bus.sgn (signed division on
// magnitudes with sign fix-up at the end); otherwise purely unsigned.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring iteration per clock, WIDTH iterations
// FIN   | done pulse, results valid; back to IDLE next clock
module seq_divider
   import div_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] div_reg;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             div_zero_r;

   logic [WIDTH-1:0] next_rem;
   logic             q_bit;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   div_step u_step (
      .rem      (rem_reg),
      .q_msb    (q_reg[WIDTH-1]),
      .divisor  (div_reg),
      .next_rem (next_rem),
      .q_bit    (q_bit)
   );

`ifdef DIV_SIGNED_EN
   logic neg_q;
   logic neg_r;
   logic neg_q_in;
   logic neg_r_in;
`endif

   always_comb begin
      q_next = {q_reg[WIDTH-2:0], q_bit};
      a_mag  = bus.dividend;
      b_mag  = bus.divisor;
      q_res  = q_next;
      r_res  = next_rem;
`ifdef DIV_SIGNED_EN
      neg_q_in = 1'b0;
      neg_r_in = 1'b0;
      if (bus.sgn) begin
         neg_r_in = bus.dividend[WIDTH-1];
         neg_q_in = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
         if (bus.dividend[WIDTH-1]) a_mag = -bus.dividend;
         if (bus.divisor[WIDTH-1])  b_mag = -bus.divisor;
      end
      // -2^31 / -1: magnitude quotient is 0x80000000 with no negation,
      // which is the wrapped result we want.
      if (neg_q) q_res = -q_next;
      if (neg_r) r_res = -next_rem;
`endif
   end

`ifdef DIV_SIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         neg_q <= neg_q_in;
         neg_r <= neg_r_in;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_reg     <= '0;
         q_reg       <= '0;
         div_reg     <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         div_zero_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r     <= 1'b1;
                  div_zero_r <= 1'b0;
                  if (bus.divisor == '0) begin
                     state       <= FIN;
                     done_r      <= 1'b1;
                     quotient_r  <= ALL_ONES;
                     remainder_r <= bus.dividend;
                     div_zero_r  <= 1'b1;
                  end else begin
                     state   <= RUN;
                     rem_reg <= '0;
                     q_reg   <= a_mag;
                     div_reg <= b_mag;
                     cnt     <= '0;
                  end
               end
            end
            RUN: begin
               rem_reg <= next_rem;
               q_reg   <= q_next;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state       <= FIN;
                  done_r      <= 1'b1;
                  quotient_r  <= q_res;
                  remainder_r <= r_res;
               end
            end
            FIN: begin
               state  <= IDLE;
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: expected results are pushed to a
// scoreboard queue when a request is issued and popped when done appears.
module tb_seq_divider;
   import div_pkg::*;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if dif ();

   seq_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb[$];

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      int   sa, sbv;
      sa  = a;
      sbv = b;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
`ifdef DIV_SIGNED_EN
         if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.q = 32'h8000_0000; e.r = 32'd0;
            end else begin
               e.q = sa / sbv; e.r = sa % sbv;
            end
         end
`else
         if (s && sa == sbv && sa == 0) e.dz = 1'b0;
`endif
      end
      return e;
   endfunction

   // Issue a request during the current cycle; accepted at the next edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      sb.push_back(model(a, b, s));
      dif.dividend = a; dif.divisor = b; dif.sgn = s; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start    = 1'b0;
      dif.dividend = $urandom;
      dif.divisor  = $urandom;
      dif.sgn      = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (dif.done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (dif.done !== 1'b1) begin
         tests_run++; tests_failed++;
         $display("FAIL done_timeout: done=%b after %0d cycles, want 1", dif.done, lat);
         lat = -1;
      end
   endtask

   task automatic test_reset();
      dif.start = 1'b0; dif.sgn = 1'b0; dif.dividend = '0; dif.divisor = '0;
      rst_n = 1'b0;
      #2;
      tests_run++;
      if ({dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder} !== 67'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                  dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", dif.busy, dif.done);
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] ta[4] = '{32'd100, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
      logic [31:0] tb[4] = '{32'd7, 32'h8000_0001, 32'h0000_1000, 32'hFFFF_FFFF};
      int   lat;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         start_op(ta[i], tb[i], 1'b0);
         tests_run++;
         if (dif.busy !== 1'b1 || dif.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL unsigned_accept[%0d]: busy=%b done=%b, want 1 0", i, dif.busy, dif.done);
         end
         wait_done(lat);
         e = sb.pop_front();
         tests_run++;
         if (lat !== 32) begin
            tests_failed++;
            $display("FAIL unsigned_latency[%0d]: %0d edges, want 32", i, lat);
         end
         tests_run++;
         if (dif.quotient !== e.q || dif.remainder !== e.r || dif.div_zero !== e.dz) begin
            tests_failed++;
            $display("FAIL unsigned_result[%0d]: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     i, dif.quotient, dif.remainder, dif.div_zero, e.q, e.r, e.dz);
         end
         tests_run++;
         if (dif.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_done[%0d]: busy=%b, want 1", i, dif.busy);
         end
         @(posedge clk); #1;
         tests_run++;
         if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse[%0d]: done=%b busy=%b, want 0 0", i, dif.done, dif.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   lat;
      exp_t e;
      start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (dif.quotient !== e.q || dif.remainder !== e.r) begin
         tests_failed++;
         $display("FAIL b2b_first: q=%h r=%h, want q=%h r=%h", dif.quotient, dif.remainder, e.q, e.r);
      end
      @(posedge clk); #1;
      start_op(32'd5, 32'd10, 1'b0);
      tests_run++;
      if (dif.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_accept: busy=%b, want 1", dif.busy);
      end
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat !== 32 || dif.quotient !== e.q || dif.remainder !== e.r) begin
         tests_failed++;
         $display("FAIL b2b_second: lat=%0d q=%h r=%h, want lat=32 q=%h r=%h",
                  lat, dif.quotient, dif.remainder, e.q, e.r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero();
      int   lat;
      exp_t e;
      start_op(32'h0000_1234, 32'd0, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat !== 0 || dif.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL dz_latency: lat=%0d busy=%b, want 0 1", lat, dif.busy);
      end
      tests_run++;
      if (dif.quotient !== e.q || dif.remainder !== e.r || dif.div_zero !== e.dz) begin
         tests_failed++;
         $display("FAIL dz_result: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                  dif.quotient, dif.remainder, dif.div_zero, e.q, e.r, e.dz);
      end
      @(posedge clk); #1;
      tests_run++;
      if (dif.done !== 1'b0 || dif.busy !== 1'b0 || dif.div_zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL dz_hold: done=%b busy=%b dz=%b, want 0 0 1", dif.done, dif.busy, dif.div_zero);
      end
      start_op(32'd9, 32'd3, 1'b0);
      tests_run++;
      if (dif.div_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL dz_clear: dz=%b, want 0", dif.div_zero);
      end
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (dif.quotient !== e.q || dif.remainder !== e.r || dif.div_zero !== e.dz) begin
         tests_failed++;
         $display("FAIL dz_next: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                  dif.quotient, dif.remainder, dif.div_zero, e.q, e.r, e.dz);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int   lat;
      int   extra;
      exp_t e;
      start_op(32'd1000, 32'd3, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      dif.start = 1'b1; dif.dividend = 32'd77; dif.divisor = 32'd7; dif.sgn = 1'b0;
      @(posedge clk); #1;
      dif.start = 1'b0;
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat + 6 !== 32) begin
         tests_failed++;
         $display("FAIL ignore_latency: %0d edges, want 32", lat + 6);
      end
      tests_run++;
      if (dif.quotient !== e.q || dif.remainder !== e.r) begin
         tests_failed++;
         $display("FAIL ignore_result: q=%h r=%h, want q=%h r=%h", dif.quotient, dif.remainder, e.q, e.r);
      end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.done === 1'b1) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL ignore_not_queued: %0d extra done pulses, want 0", extra);
      end
   endtask

   task automatic test_reset_midrun();
      int   lat;
      int   extra;
      exp_t e;
      start_op(32'd25, 32'd5, 1'b0);
      sb.delete();
      repeat (10) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder} !== 67'd0) begin
         tests_failed++;
         $display("FAIL midrun_reset: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                  dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.done === 1'b1 || dif.busy === 1'b1) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL midrun_abandon: %0d cycles with busy/done, want 0", extra);
      end
      start_op(32'd25, 32'd5, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat !== 32 || dif.quotient !== e.q || dif.remainder !== e.r) begin
         tests_failed++;
         $display("FAIL midrun_restart: lat=%0d q=%h r=%h, want lat=32 q=%h r=%h",
                  lat, dif.quotient, dif.remainder, e.q, e.r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sgn();
`ifdef DIV_SIGNED_EN
      logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF8};
      logic [31:0] tb[4] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
`else
      logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF8};
      logic [31:0] tb[4] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3};
`endif
      int   lat;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         start_op(ta[i], tb[i], 1'b1);
         wait_done(lat);
         e = sb.pop_front();
         tests_run++;
         if (lat !== ((tb[i] == 32'd0) ? 0 : 32)) begin
            tests_failed++;
            $display("FAIL sgn_latency[%0d]: %0d edges", i, lat);
         end
         tests_run++;
         if (dif.quotient !== e.q || dif.remainder !== e.r || dif.div_zero !== e.dz) begin
            tests_failed++;
            $display("FAIL sgn_result[%0d]: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     i, dif.quotient, dif.remainder, dif.div_zero, e.q, e.r, e.dz);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_back_to_back();
      test_div_zero();
      test_start_ignored();
      test_reset_midrun();
      test_sgn();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
